// File: rtl/filter_pkg.sv
// Shared types and default frame geometry for the frame filter scheduler.
package filter_pkg;

    localparam int unsigned IMG_W_DEFAULT  = 100;
    localparam int unsigned IMG_H_DEFAULT  = 100;
    localparam int unsigned ADDR_W_DEFAULT = 14;
    localparam int unsigned PIX_W          = 8;

    typedef enum logic [1:0] {
        FILT_PASS = 2'b00,
        FILT_INV  = 2'b01,
        FILT_THR  = 2'b10,
        FILT_BRT  = 2'b11
    } filter_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } sched_state_t;

endpackage

// File: rtl/filter_scheduler_if.sv
// Control plus source-read / result-write bus of the filter scheduler.
interface filter_scheduler_if #(
    parameter int unsigned ADDR_W = filter_pkg::ADDR_W_DEFAULT
);
    logic              start;
    logic [1:0]        filterSelector;
    logic              rdReq;
    logic [ADDR_W-1:0] rdAddr;
    logic              rdAck;
    logic [7:0]        rdData;
    logic              wrReq;
    logic [ADDR_W-1:0] wrAddr;
    logic [7:0]        wrData;
    logic              wrAck;
    logic              busy;
    logic              done;

    modport master (
        input  start, filterSelector, rdAck, rdData, wrAck,
        output rdReq, rdAddr, wrReq, wrAddr, wrData, busy, done
    );

    modport slave (
        output start, filterSelector, rdAck, rdData, wrAck,
        input  rdReq, rdAddr, wrReq, wrAddr, wrData, busy, done
    );
endinterface

// File: rtl/pixel_op.sv
// Combinational point operation applied to one source pixel.
module pixel_op
    import filter_pkg::*;
(
    input  logic [PIX_W-1:0] pix,
    input  filter_sel_t      sel,
    output logic [PIX_W-1:0] result_c
);

    logic [PIX_W:0] bright_sum;

    always_comb begin
        bright_sum = {1'b0, pix} + (PIX_W+1)'(32);
        result_c   = pix;
        case (sel)
            FILT_PASS: result_c = pix;
            FILT_INV:  result_c = ~pix;
            FILT_THR:  result_c = pix[PIX_W-1] ? '1 : '0;
            FILT_BRT:  result_c = bright_sum[PIX_W] ? '1 : bright_sum[PIX_W-1:0];
            default:   result_c = pix;
        endcase
    end

endmodule

// File: rtl/filter_scheduler.sv
// Walks a frame pixel by pixel: read source, apply the latched point filter,
// write the result, one outstanding transaction at a time.
module filter_scheduler
    import filter_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEFAULT,
    parameter int unsigned IMG_H  = IMG_H_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    filter_scheduler_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

    sched_state_t      state, state_n;
    logic [ADDR_W-1:0] counter, counter_n;
    filter_sel_t       filt, filt_n;
    logic              rd_req, rd_req_n;
    logic [ADDR_W-1:0] rd_addr, rd_addr_n;
    logic              wr_req, wr_req_n;
    logic [ADDR_W-1:0] wr_addr, wr_addr_n;
    logic [PIX_W-1:0]  wr_data, wr_data_n;
    logic              busy, busy_n;
    logic              done, done_n;
    logic [PIX_W-1:0]  op_pix_c;

    pixel_op u_pixel_op (
        .pix      (bus.rdData),
        .sel      (filt),
        .result_c (op_pix_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            filt    <= FILT_PASS;
            rd_req  <= 1'b0;
            rd_addr <= '0;
            wr_req  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            counter <= counter_n;
            filt    <= filt_n;
            rd_req  <= rd_req_n;
            rd_addr <= rd_addr_n;
            wr_req  <= wr_req_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state logic also computes next values of every registered output.
    always_comb begin
        state_n   = state;
        counter_n = counter;
        filt_n    = filt;
        rd_req_n  = rd_req;
        rd_addr_n = rd_addr;
        wr_req_n  = wr_req;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    filt_n    = filter_sel_t'(bus.filterSelector);
                    counter_n = '0;
                    rd_addr_n = '0;
                    rd_req_n  = 1'b1;
                    state_n   = READ;
                end
            end
            READ: begin
                if (bus.rdAck) begin
                    wr_data_n = op_pix_c;
                    wr_addr_n = counter;
                    rd_req_n  = 1'b0;
                    wr_req_n  = 1'b1;
                    state_n   = WRITE;
                end
            end
            WRITE: begin
                if (bus.wrAck) begin
                    wr_req_n = 1'b0;
                    if (counter == LAST_PIX) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        counter_n = counter + ADDR_W'(1);
                        rd_addr_n = counter + ADDR_W'(1);
                        rd_req_n  = 1'b1;
                        state_n   = READ;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.rdReq  = rd_req;
    assign bus.rdAddr = rd_addr;
    assign bus.wrReq  = wr_req;
    assign bus.wrAddr = wr_addr;
    assign bus.wrData = wr_data;
    assign bus.busy   = busy;
    assign bus.done   = done;

endmodule

// File: tb/tb_filter_scheduler.sv
// Directed self-checking bench for filter_scheduler with a memory responder.
module tb_filter_scheduler;
    import filter_pkg::*;

    localparam int unsigned AW    = ADDR_W_DEFAULT;
    localparam int unsigned N_PIX = IMG_W_DEFAULT * IMG_H_DEFAULT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    filter_scheduler_if #(.ADDR_W(AW)) bus ();

    filter_scheduler #(
        .IMG_W  (IMG_W_DEFAULT),
        .IMG_H  (IMG_H_DEFAULT),
        .ADDR_W (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit         tie_high = 1'b1;
    int         rd_delay = 0;
    int         wr_delay = 0;
    int         rd_wait  = 0;
    int         wr_wait  = 0;
    bit         src_from_tab = 1'b0;
    logic [7:0] src_const = 8'h00;
    logic [7:0] src_tab [2];

    logic [1:0] exp_sel = 2'b00;
    int exp_addr = 0, write_cnt = 0, order_err = 0, data_err = 0;
    int stab_err = 0, overlap_err = 0, done_cnt = 0, done_cyc = 0;
    logic [7:0] wr_log [4];
    int         wr_addr_log [4];

    bit          p_rd_req = 0, p_rd_ack = 0, p_wr_req = 0, p_wr_ack = 0;
    logic [AW-1:0] p_rd_addr = '0, p_wr_addr = '0;
    logic [7:0]  p_wr_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] src_pix(input logic [AW-1:0] a);
        if (src_from_tab && a < AW'(2)) return src_tab[a[0]];
        return src_const;
    endfunction

    function automatic logic [7:0] model(input logic [1:0] s, input logic [7:0] p);
        int sum;
        sum = int'(p) + 32;
        case (s)
            2'b00:   return p;
            2'b01:   return 8'hFF - p;
            2'b10:   return (p >= 8'd128) ? 8'hFF : 8'h00;
            default: return (sum > 255) ? 8'hFF : 8'(sum);
        endcase
    endfunction

    // Memory responder plus protocol and write scoreboard, all on the falling edge.
    initial begin
        bus.rdAck  = 1'b0;
        bus.wrAck  = 1'b0;
        bus.rdData = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.rdReq && bus.wrReq) overlap_err++;
            if (p_rd_req && !p_rd_ack && (!bus.rdReq || bus.rdAddr !== p_rd_addr)) stab_err++;
            if (p_wr_req && !p_wr_ack &&
                (!bus.wrReq || bus.wrAddr !== p_wr_addr || bus.wrData !== p_wr_data)) stab_err++;
            if (tie_high) begin
                bus.rdAck = 1'b1;
                bus.wrAck = 1'b1;
            end else begin
                if (bus.rdReq) begin
                    bus.rdAck = (rd_wait == rd_delay);
                    rd_wait   = bus.rdAck ? 0 : rd_wait + 1;
                end else begin
                    bus.rdAck = 1'b0;
                    rd_wait   = 0;
                end
                if (bus.wrReq) begin
                    bus.wrAck = (wr_wait == wr_delay);
                    wr_wait   = bus.wrAck ? 0 : wr_wait + 1;
                end else begin
                    bus.wrAck = 1'b0;
                    wr_wait   = 0;
                end
            end
            bus.rdData = src_pix(bus.rdAddr);
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc - t0;
            end
            if (bus.wrReq && bus.wrAck) begin
                if (int'(bus.wrAddr) != exp_addr) order_err++;
                if (bus.wrData !== model(exp_sel, src_pix(AW'(exp_addr)))) data_err++;
                if (write_cnt < 4) begin
                    wr_log[write_cnt]      = bus.wrData;
                    wr_addr_log[write_cnt] = int'(bus.wrAddr);
                end
                write_cnt++;
                exp_addr++;
            end
            p_rd_req  = bus.rdReq;
            p_rd_ack  = bus.rdAck;
            p_rd_addr = bus.rdAddr;
            p_wr_req  = bus.wrReq;
            p_wr_ack  = bus.wrAck;
            p_wr_addr = bus.wrAddr;
            p_wr_data = bus.wrData;
        end
    end

    task automatic run_start(input logic [1:0] sel);
        @(negedge clk);
        exp_sel = sel; exp_addr = 0; write_cnt = 0; order_err = 0; data_err = 0;
        stab_err = 0; overlap_err = 0; done_cnt = 0; done_cyc = 0;
        bus.filterSelector = sel;
        bus.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && write_cnt < n; i++) @(negedge clk);
        check(tag, 32'(write_cnt >= n), 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdReq"},  32'(bus.rdReq),  32'd0);
        check({tag, "_wrReq"},  32'(bus.wrReq),  32'd0);
        check({tag, "_done"},   32'(bus.done),   32'd0);
        check({tag, "_busy"},   32'(bus.busy),   32'd0);
        check({tag, "_rdAddr"}, 32'(bus.rdAddr), 32'd0);
        check({tag, "_wrAddr"}, 32'(bus.wrAddr), 32'd0);
        check({tag, "_wrData"}, 32'(bus.wrData), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.filterSelector = 2'b00;
        src_tab[0] = 8'h00;
        src_tab[1] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_start_busy", 32'(bus.busy), 32'd0);

        // Full frame, acks tied high, invert; mid-pass start and selector change must be ignored.
        src_const = 8'h10;
        run_start(2'b01);
        check("s1_busy_running", 32'(bus.busy), 32'd1);
        repeat (4998) @(negedge clk);
        bus.start = 1'b1;
        bus.filterSelector = 2'b10;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2 * int'(N_PIX) && done_cnt == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("s1_writes",   32'(write_cnt),   32'(N_PIX));
        check("s1_order",    32'(order_err),   32'd0);
        check("s1_data",     32'(data_err),    32'd0);
        check("s1_done_cnt", 32'(done_cnt),    32'd1);
        check("s1_done_cyc", 32'(done_cyc),    32'd20001);
        check("s1_overlap",  32'(overlap_err), 32'd0);
        check("s1_busy_end", 32'(bus.busy),    32'd0);

        // Brighten with slow acks: saturation, stability while waiting.
        bus.filterSelector = 2'b00;
        src_from_tab = 1'b1;
        src_tab[0] = 8'hF0;
        src_tab[1] = 8'h05;
        src_const  = 8'h40;
        tie_high = 1'b0;
        rd_delay = 3;
        wr_delay = 2;
        run_start(2'b11);
        wait_writes(8, 400, "s2_progress");
        check("s2_wr0",     32'(wr_log[0]),   32'h0000_00FF);
        check("s2_wr1",     32'(wr_log[1]),   32'h0000_0025);
        check("s2_stable",  32'(stab_err),    32'd0);
        check("s2_overlap", 32'(overlap_err), 32'd0);
        check("s2_order",   32'(order_err),   32'd0);
        check("s2_data",    32'(data_err),    32'd0);
        apply_reset();

        // Threshold around the 128 boundary.
        tie_high = 1'b1;
        src_tab[0] = 8'h7F;
        src_tab[1] = 8'h80;
        run_start(2'b10);
        wait_writes(2, 50, "s3_progress");
        check("s3_wr0", 32'(wr_log[0]), 32'h0000_0000);
        check("s3_wr1", 32'(wr_log[1]), 32'h0000_00FF);
        apply_reset();

        // Abort during the write of pixel 500, then restart from address 0.
        src_from_tab = 1'b0;
        src_const = 8'h5A;
        run_start(2'b00);
        for (int i = 0; i < 2000 && !(bus.wrReq && bus.wrAddr == AW'(500)); i++) @(negedge clk);
        check("s4_reach_500", 32'(bus.wrReq && bus.wrAddr == AW'(500)), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("s4_abort");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("s4_no_done",   32'(done_cnt), 32'd0);
        check("s4_idle_busy", 32'(bus.busy), 32'd0);
        run_start(2'b00);
        check("s4_restart_rdReq",  32'(bus.rdReq),  32'd1);
        check("s4_restart_rdAddr", 32'(bus.rdAddr), 32'd0);
        wait_writes(2, 50, "s4_progress");
        check("s4_restart_wrAddr", 32'(wr_addr_log[0]), 32'd0);
        check("s4_restart_wrData", 32'(wr_log[0]),      32'h0000_005A);
        apply_reset();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
